logic_timer_arbiter: RTL and testbench

// Shares one AXI4-Stream countdown timer between REQUESTERS independent clients
// (PLL lock services, reset sequencers, watchdogs). Accepts one timeout request at
// a time by round-robin arbitration, loads the timer, waits for its expiry event
// and returns a one-beat expiry event to the owning client. Sits between the

---
 rtl/logic_timer_arbiter.sv | 78 +++++++
 tb/tb_logic_timer_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/logic_timer_arbiter.sv
// logic_timer_arbiter: round-robin sharing of one countdown timer among several clients
module logic_timer_arbiter #(
    parameter int REQUESTERS  = 4,
    parameter int TIMER_WIDTH = 32,
    localparam int OWNER_WIDTH = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
    input  logic                              aclk,
    input  logic                              areset_n,
    input  logic [REQUESTERS-1:0]             req_tvalid,
    input  logic [REQUESTERS*TIMER_WIDTH-1:0] req_tdata,
    output logic [REQUESTERS-1:0]             req_tready,
    output logic [REQUESTERS-1:0]             evt_tvalid,
    input  logic [REQUESTERS-1:0]             evt_tready,
    output logic                              timer_config_tvalid,
    output logic [TIMER_WIDTH-1:0]            timer_config_tdata,
    output logic                              timer_config_tlast,
    input  logic                              timer_config_tready,
    input  logic                              timer_tvalid,
    input  logic                              timer_tlast,
    output logic                              timer_tready,
    output logic                              busy,
    output logic [OWNER_WIDTH-1:0]            owner
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, NOTIFY} state_t;
    state_t state, state_next;
    logic [OWNER_WIDTH-1:0] last_grant, winner, idx;
    logic [TIMER_WIDTH-1:0] count, sel_data;
    logic found, accept, evt_ack;
    // pick the first requester after the previous grant, wrapping around
    always_comb begin
        found = 1'b0;
        winner = '0;
        idx = '0;
        sel_data = '0;
        for (int k = 1; k <= REQUESTERS; k++) begin
            idx = OWNER_WIDTH'((int'(last_grant) + k) % REQUESTERS);
            if (!found && req_tvalid[idx]) begin
                found = 1'b1;
                winner = idx;
                sel_data = req_tdata[int'(idx)*TIMER_WIDTH +: TIMER_WIDTH];
            end
        end
    end
    // handshake decodes and next-state logic
    always_comb begin
        state_next = IDLE;
        accept = (state == IDLE) && found;
        evt_ack = (state == NOTIFY) && evt_tready[owner];
        req_tready = REQUESTERS'(accept) << winner;
        evt_tvalid = REQUESTERS'(state == NOTIFY) << owner;
        timer_config_tvalid = (state == LOAD);
        timer_config_tdata = count;
        timer_config_tlast = 1'b1;
        timer_tready = (state == RUN);
        state_next = (state == IDLE)   ? (accept ? ((sel_data == '0) ? NOTIFY : LOAD) : IDLE) :
                     (state == LOAD)   ? (timer_config_tready ? RUN : LOAD) :
                     (state == RUN)    ? ((timer_tvalid && timer_tlast) ? NOTIFY : RUN) :
                     (state == NOTIFY) ? (evt_ack ? IDLE : NOTIFY) : IDLE;
    end
    // state, ownership and loaded count registers
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            state <= IDLE;
            last_grant <= OWNER_WIDTH'(REQUESTERS - 1);
            owner <= '0;
            count <= '0;
            busy <= 1'b0;
        end else begin
            state <= state_next;
            busy <= (state_next != IDLE);
            if (accept) begin
                owner <= winner;
                count <= sel_data;
                last_grant <= winner;
            end
        end
    end
endmodule

// File: tb/tb_logic_timer_arbiter.sv
// tb_logic_timer_arbiter: directed checks of arbitration, timer handshakes and events
module tb_logic_timer_arbiter;
    logic         aclk = 1'b0;
    logic         areset_n;
    logic [3:0]   req_tvalid, req_tready, evt_tvalid, evt_tready;
    logic [127:0] req_tdata;
    logic         timer_config_tvalid, timer_config_tlast, timer_config_tready;
    logic [31:0]  timer_config_tdata;
    logic         timer_tvalid, timer_tlast, timer_tready, busy;
    logic [1:0]   owner;
    int total = 0;
    int bad = 0;

    logic_timer_arbiter dut (
        .aclk(aclk), .areset_n(areset_n),
        .req_tvalid(req_tvalid), .req_tdata(req_tdata), .req_tready(req_tready),
        .evt_tvalid(evt_tvalid), .evt_tready(evt_tready),
        .timer_config_tvalid(timer_config_tvalid), .timer_config_tdata(timer_config_tdata),
        .timer_config_tlast(timer_config_tlast), .timer_config_tready(timer_config_tready),
        .timer_tvalid(timer_tvalid), .timer_tlast(timer_tlast), .timer_tready(timer_tready),
        .busy(busy), .owner(owner)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        areset_n = 1'b0;
        req_tvalid = '0;
        req_tdata = '0;
        evt_tready = '0;
        timer_config_tready = 1'b0;
        timer_tvalid = 1'b0;
        timer_tlast = 1'b0;
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'(1'b0));
        chk("rst_owner", 64'(owner), 64'(2'd0));
        chk("rst_req_tready", 64'(req_tready), 64'(4'b0000));
        chk("rst_evt_tvalid", 64'(evt_tvalid), 64'(4'b0000));
        chk("rst_cfg_tvalid", 64'(timer_config_tvalid), 64'(1'b0));
        chk("rst_cfg_tdata", 64'(timer_config_tdata), 64'(32'd0));
        chk("rst_timer_tready", 64'(timer_tready), 64'(1'b0));
        chk("cfg_tlast", 64'(timer_config_tlast), 64'(1'b1));
        areset_n = 1'b1;
        tick();
        // client 2 requests 100
        req_tvalid = 4'b0100;
        req_tdata[64 +: 32] = 32'd100;
        #1;
        chk("t1_req_tready", 64'(req_tready), 64'(4'b0100));
        tick();
        req_tvalid = '0;
        #1;
        chk("t1_cfg_tvalid", 64'(timer_config_tvalid), 64'(1'b1));
        chk("t1_cfg_tdata", 64'(timer_config_tdata), 64'(32'd100));
        chk("t1_owner", 64'(owner), 64'(2'd2));
        chk("t1_busy", 64'(busy), 64'(1'b1));
        chk("t1_req_tready_busy", 64'(req_tready), 64'(4'b0000));
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("load_hold_tvalid", 64'(timer_config_tvalid), 64'(1'b1));
            chk("load_hold_tdata", 64'(timer_config_tdata), 64'(32'd100));
        end
        timer_config_tready = 1'b1;
        tick();
        timer_config_tready = 1'b0;
        chk("run_timer_tready", 64'(timer_tready), 64'(1'b1));
        chk("run_cfg_tvalid", 64'(timer_config_tvalid), 64'(1'b0));
        timer_tvalid = 1'b1;
        timer_tlast = 1'b0;
        tick();
        chk("nolast_evt", 64'(evt_tvalid), 64'(4'b0000));
        chk("nolast_timer_tready", 64'(timer_tready), 64'(1'b1));
        timer_tlast = 1'b1;
        tick();
        timer_tvalid = 1'b0;
        timer_tlast = 1'b0;
        chk("expiry_evt", 64'(evt_tvalid), 64'(4'b0100));
        chk("expiry_timer_tready", 64'(timer_tready), 64'(1'b0));
        req_tvalid = 4'b0001;
        #1;
        chk("notify_req_tready", 64'(req_tready), 64'(4'b0000));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("evt_hold", 64'(evt_tvalid), 64'(4'b0100));
        end
        req_tvalid = '0;
        evt_tready = 4'b0100;
        tick();
        evt_tready = '0;
        chk("after_evt_busy", 64'(busy), 64'(1'b0));
        chk("after_evt_evt", 64'(evt_tvalid), 64'(4'b0000));
        // client 1 requests zero: timer skipped
        req_tvalid = 4'b0010;
        req_tdata[32 +: 32] = 32'd0;
        #1;
        chk("z_req_tready", 64'(req_tready), 64'(4'b0010));
        tick();
        req_tvalid = '0;
        chk("z_cfg_tvalid", 64'(timer_config_tvalid), 64'(1'b0));
        chk("z_evt", 64'(evt_tvalid), 64'(4'b0010));
        chk("z_owner", 64'(owner), 64'(2'd1));
        evt_tready = 4'b0010;
        tick();
        evt_tready = '0;
        chk("z_done_busy", 64'(busy), 64'(1'b0));
        // client 3 reaches RUN, then reset
        req_tvalid = 4'b1000;
        req_tdata[96 +: 32] = 32'd5;
        #1;
        chk("r_req_tready", 64'(req_tready), 64'(4'b1000));
        timer_config_tready = 1'b1;
        tick();
        req_tvalid = '0;
        tick();
        timer_config_tready = 1'b0;
        chk("r_run", 64'(timer_tready), 64'(1'b1));
        areset_n = 1'b0;
        tick();
        areset_n = 1'b1;
        chk("r_busy", 64'(busy), 64'(1'b0));
        chk("r_timer_tready", 64'(timer_tready), 64'(1'b0));
        chk("r_owner", 64'(owner), 64'(2'd0));
        timer_tvalid = 1'b1;
        timer_tlast = 1'b1;
        tick();
        timer_tvalid = 1'b0;
        timer_tlast = 1'b0;
        chk("r_no_evt", 64'(evt_tvalid), 64'(4'b0000));
        // all four request continuously, count 3
        req_tdata = {4{32'd3}};
        req_tvalid = 4'b1111;
        timer_config_tready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            #1;
            chk("rr_req_tready", 64'(req_tready), 64'(4'b0001 << (g % 4)));
            tick();
            chk("rr_owner", 64'(owner), 64'(g % 4));
            chk("rr_cfg_tdata", 64'(timer_config_tdata), 64'(32'd3));
            chk("rr_cfg_tvalid", 64'(timer_config_tvalid), 64'(1'b1));
            tick();
            timer_tvalid = 1'b1;
            timer_tlast = 1'b1;
            #1;
            chk("rr_run_req_tready", 64'(req_tready), 64'(4'b0000));
            tick();
            timer_tvalid = 1'b0;
            timer_tlast = 1'b0;
            chk("rr_evt", 64'(evt_tvalid), 64'(4'b0001 << (g % 4)));
            evt_tready = 4'b1111;
            tick();
            evt_tready = '0;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
